// File: rtl/unsharp_mask_frame_buf_if.sv
// ============================================================================
// Module  : unsharp_mask_frame_buf_if
// Brief   : Pixel streams, ap_ctrl_hs handshake and core memory ports.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface unsharp_mask_frame_buf_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              out_ready;
    logic              ap_start;
    logic              ap_ready;
    logic              ap_done;
    logic              img_ce0;
    logic [ADDR_W-1:0] img_address0;
    logic [DATA_W-1:0] img_q0;
    logic              mask_img_ce0;
    logic              mask_img_we0;
    logic [ADDR_W-1:0] mask_img_address0;
    logic [DATA_W-1:0] mask_img_d0;
    logic              busy;
    logic              err;

    // Frame buffer side.
    modport slave (
        input  in_valid, in_data, out_ready, ap_ready, ap_done,
        input  img_ce0, img_address0,
        input  mask_img_ce0, mask_img_we0, mask_img_address0, mask_img_d0,
        output in_ready, out_valid, out_data, out_last, ap_start,
        output img_q0, busy, err
    );

    // Stream source/sink and core side.
    modport master (
        output in_valid, in_data, out_ready, ap_ready, ap_done,
        output img_ce0, img_address0,
        output mask_img_ce0, mask_img_we0, mask_img_address0, mask_img_d0,
        input  in_ready, out_valid, out_data, out_last, ap_start,
        input  img_q0, busy, err
    );
endinterface

`default_nettype wire

// File: rtl/unsharp_mask_frame_buf.sv
// ============================================================================
// Module  : unsharp_mask_frame_buf
// Brief   : Frame buffer front/back end around the unsharp-mask HLS core.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module unsharp_mask_frame_buf #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 10,
    parameter int NUM_PIX = 1024
) (
    input  logic                           clk,
    input  logic                           rst,
    unsharp_mask_frame_buf_if.slave        bus
);

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_DRAIN = 2'd3
    } state_e;

    localparam int                DEPTH     = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIX - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] wr_cnt_q, wr_cnt_d;
    logic [ADDR_W-1:0] rd_cnt_q, rd_cnt_d;
    logic              rd_done_q, rd_done_d;
    logic              rd_vld_q, rd_last_q;
    logic [DATA_W-1:0] rd_data_q;
    logic [1:0]        sk_cnt_q;
    logic [DATA_W-1:0] sk0_data_q, sk1_data_q;
    logic              sk0_last_q, sk1_last_q;
    logic              err_q;
    logic [DATA_W-1:0] img_q_q;

    logic [DATA_W-1:0] img_mem  [DEPTH];
    logic [DATA_W-1:0] mask_mem [DEPTH];

    logic       in_ready_w, in_fire_w;
    logic       mask_wr_w, mask_wr_ok_w;
    logic       pop_w, push_w, last_pop_w, rd_issue_w;
    logic [2:0] occ_w;

    // in_ready is gated by rst so it reads 0 while reset is held.
    always_comb begin
        in_ready_w   = rst && (state_q == S_LOAD);
        in_fire_w    = in_ready_w && bus.in_valid;
        mask_wr_w    = bus.mask_img_ce0 && bus.mask_img_we0;
        mask_wr_ok_w = mask_wr_w && ((state_q == S_START) || (state_q == S_WAIT));
        pop_w        = (state_q == S_DRAIN) && (sk_cnt_q != 2'd0) && bus.out_ready;
        push_w       = rd_vld_q;
        last_pop_w   = pop_w && sk0_last_q;
        // Issue a read only if it is guaranteed a skid slot when it lands.
        occ_w        = 3'(sk_cnt_q) + 3'(rd_vld_q);
        rd_issue_w   = (state_q == S_DRAIN) && !rd_done_q
                       && (occ_w < (pop_w ? 3'd3 : 3'd2));
    end

    always_comb begin
        state_d   = state_q;
        wr_cnt_d  = wr_cnt_q;
        rd_cnt_d  = rd_cnt_q;
        rd_done_d = rd_done_q;
        case (state_q)
            S_LOAD: begin
                if (in_fire_w) begin
                    if (wr_cnt_q == LAST_ADDR) begin
                        wr_cnt_d = '0;
                        state_d  = S_START;
                    end else begin
                        wr_cnt_d = wr_cnt_q + 1'b1;
                    end
                end
            end
            S_START: begin
                if (bus.ap_ready) begin
                    state_d = bus.ap_done ? S_DRAIN : S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.ap_done) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (rd_issue_w) begin
                    if (rd_cnt_q == LAST_ADDR) begin
                        rd_done_d = 1'b1;
                    end else begin
                        rd_cnt_d = rd_cnt_q + 1'b1;
                    end
                end
                if (last_pop_w) begin
                    rd_cnt_d  = '0;
                    rd_done_d = 1'b0;
                    state_d   = S_LOAD;
                end
            end
            default: state_d = S_LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_LOAD;
            wr_cnt_q  <= '0;
            rd_cnt_q  <= '0;
            rd_done_q <= 1'b0;
            rd_vld_q  <= 1'b0;
            rd_last_q <= 1'b0;
            err_q     <= 1'b0;
            img_q_q   <= '0;
        end else begin
            state_q   <= state_d;
            wr_cnt_q  <= wr_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
            rd_done_q <= rd_done_d;
            rd_vld_q  <= rd_issue_w;
            rd_last_q <= rd_issue_w && (rd_cnt_q == LAST_ADDR);
            if ((mask_wr_w && !mask_wr_ok_w) || (bus.img_ce0 && (state_q == S_LOAD))) begin
                err_q <= 1'b1;
            end
            if (bus.img_ce0) begin
                img_q_q <= img_mem[bus.img_address0];
            end
        end
    end

    // Two-entry output skid; entry 0 always feeds the stream.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sk_cnt_q   <= 2'd0;
            sk0_data_q <= '0;
            sk1_data_q <= '0;
            sk0_last_q <= 1'b0;
            sk1_last_q <= 1'b0;
        end else begin
            if (pop_w) begin
                if (sk_cnt_q == 2'd2) begin
                    sk0_data_q <= sk1_data_q;
                    sk0_last_q <= sk1_last_q;
                    if (push_w) begin
                        sk1_data_q <= rd_data_q;
                        sk1_last_q <= rd_last_q;
                    end
                end else if (push_w) begin
                    sk0_data_q <= rd_data_q;
                    sk0_last_q <= rd_last_q;
                end
            end else if (push_w) begin
                if (sk_cnt_q == 2'd0) begin
                    sk0_data_q <= rd_data_q;
                    sk0_last_q <= rd_last_q;
                end else begin
                    sk1_data_q <= rd_data_q;
                    sk1_last_q <= rd_last_q;
                end
            end
            case ({push_w, pop_w})
                2'b10:   sk_cnt_q <= sk_cnt_q + 2'd1;
                2'b01:   sk_cnt_q <= sk_cnt_q - 2'd1;
                default: sk_cnt_q <= sk_cnt_q;
            endcase
        end
    end

    // Buffer storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (in_fire_w) begin
            img_mem[wr_cnt_q] <= bus.in_data;
        end
        if (mask_wr_ok_w) begin
            mask_mem[bus.mask_img_address0] <= bus.mask_img_d0;
        end
        if (rd_issue_w) begin
            rd_data_q <= mask_mem[rd_cnt_q];
        end
    end

    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = (state_q == S_DRAIN) && (sk_cnt_q != 2'd0);
    assign bus.out_data  = sk0_data_q;
    assign bus.out_last  = (state_q == S_DRAIN) && (sk_cnt_q != 2'd0) && sk0_last_q;
    assign bus.ap_start  = (state_q == S_START);
    assign bus.busy      = (state_q != S_LOAD);
    assign bus.err       = err_q;
    assign bus.img_q0    = img_q_q;

endmodule

`default_nettype wire

// File: tb/tb_unsharp_mask_frame_buf.sv
// ============================================================================
// Module  : tb_unsharp_mask_frame_buf
// Brief   : Directed self-checking bench for unsharp_mask_frame_buf.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_unsharp_mask_frame_buf;
    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 10;
    localparam int NUM_PIX = 1024;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    unsharp_mask_frame_buf_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    unsharp_mask_frame_buf #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .NUM_PIX(NUM_PIX)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [DATA_W-1:0] exp_img  [NUM_PIX];
    logic [DATA_W-1:0] exp_mask [NUM_PIX];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic core_idle();
        bus.ap_ready          = 1'b0;
        bus.ap_done           = 1'b0;
        bus.img_ce0           = 1'b0;
        bus.img_address0      = '0;
        bus.mask_img_ce0      = 1'b0;
        bus.mask_img_we0      = 1'b0;
        bus.mask_img_address0 = '0;
        bus.mask_img_d0       = '0;
    endtask

    task automatic load_frame(input int n, input int kind);
        logic [DATA_W-1:0] d;
        for (int a = 0; a < n; a++) begin
            case (kind)
                0:       d = 32'(a);
                1:       d = 32'h0000_1000 + 32'(a);
                2:       d = 32'd7;
                default: d = 32'hA000_0000 + 32'(a);
            endcase
            exp_img[a] = d;
            chk("in_ready_load", bus.in_ready, 1);
            bus.in_valid = 1'b1;
            bus.in_data  = d;
            step();
        end
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
    endtask

    task automatic core_start(output int t0);
        chk("ap_start_rise", bus.ap_start, 1);
        chk("in_ready_start", bus.in_ready, 0);
        t0 = cyc;
        step();
        chk("ap_start_held", bus.ap_start, 1);
        bus.ap_ready = 1'b1;
        step();
        bus.ap_ready = 1'b0;
        chk("ap_start_drop", bus.ap_start, 0);
    endtask

    // Core model: read img[k], write mask[k-1] = img[k-1] + 1 one cycle later.
    task automatic core_rw();
        bit restart;
        restart = 1'b0;
        for (int k = 0; k <= NUM_PIX; k++) begin
            bus.img_ce0           = (k < NUM_PIX);
            bus.img_address0      = ADDR_W'(k);
            bus.mask_img_ce0      = (k > 0);
            bus.mask_img_we0      = (k > 0);
            bus.mask_img_address0 = ADDR_W'(k - 1);
            bus.mask_img_d0       = bus.img_q0 + 32'd1;
            step();
            if (bus.ap_start) restart = 1'b1;
        end
        core_idle();
        for (int a = 0; a < NUM_PIX; a++) exp_mask[a] = exp_img[a] + 32'd1;
        chk("ap_start_single", restart, 0);
    endtask

    task automatic core_done(input int t0);
        while (cyc - t0 < 1100) step();
        bus.ap_done = 1'b1;
        step();
        bus.ap_done = 1'b0;
    endtask

    task automatic check_latency();
        chk("drain_lat0", bus.out_valid, 0);
        step();
        chk("drain_lat1", bus.out_valid, 0);
        step();
        chk("drain_lat2", bus.out_valid, 1);
        chk("drain_first", bus.out_data, exp_mask[0]);
    endtask

    task automatic drain(input int mode);
        int                idx;
        int                k;
        bit                rdy;
        bit                stalled;
        logic [DATA_W-1:0] st_data;
        logic              st_last;
        idx     = 0;
        k       = 0;
        stalled = 1'b0;
        st_data = '0;
        st_last = 1'b0;
        while (idx < NUM_PIX && k < 5000) begin
            if (stalled) begin
                chk("stall_valid", bus.out_valid, 1);
                chk("stall_data", bus.out_data, st_data);
                chk("stall_last", bus.out_last, st_last);
            end
            rdy = (mode == 0) ? 1'b1 : ((k % 4 == 0) || (k % 4 == 3));
            bus.out_ready = rdy;
            if (bus.out_valid && rdy) begin
                chk("out_data", bus.out_data, exp_mask[idx]);
                chk("out_last", bus.out_last, (idx == NUM_PIX - 1));
                idx++;
                stalled = 1'b0;
            end else if (bus.out_valid) begin
                stalled = 1'b1;
                st_data = bus.out_data;
                st_last = bus.out_last;
            end else begin
                stalled = 1'b0;
            end
            step();
            k++;
        end
        bus.out_ready = 1'b0;
        chk("drain_count", idx, NUM_PIX);
        chk("drain_end_valid", bus.out_valid, 0);
        chk("drain_end_busy", bus.busy, 0);
        chk("drain_end_ready", bus.in_ready, 1);
    endtask

    initial begin
        int t0;
        rst           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        core_idle();
        step();
        step();
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_last", bus.out_last, 0);
        chk("rst_ap_start", bus.ap_start, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_img_q0", bus.img_q0, 0);
        rst = 1'b1;
        #1;
        chk("post_rst_in_ready", bus.in_ready, 1);
        chk("post_rst_busy", bus.busy, 0);

        // Smoke frame plus read-latency probe while the core is in WAIT.
        load_frame(NUM_PIX, 0);
        core_start(t0);
        core_rw();
        bus.img_ce0      = 1'b1;
        bus.img_address0 = ADDR_W'(5);
        step();
        bus.img_ce0      = 1'b0;
        chk("img_rd_lat", bus.img_q0, exp_img[5]);
        bus.img_address0 = ADDR_W'(9);
        step();
        step();
        chk("img_rd_hold", bus.img_q0, exp_img[5]);
        core_done(t0);
        check_latency();
        drain(0);
        chk("smoke_err", bus.err, 0);

        // Backpressure frame.
        load_frame(NUM_PIX, 1);
        core_start(t0);
        core_rw();
        core_done(t0);
        drain(1);

        // ap_ready and ap_done together: mask keeps the previous frame.
        load_frame(NUM_PIX, 3);
        chk("coinc_ap_start_pre", bus.ap_start, 1);
        bus.ap_ready = 1'b1;
        bus.ap_done  = 1'b1;
        step();
        bus.ap_ready = 1'b0;
        bus.ap_done  = 1'b0;
        chk("coinc_ap_start", bus.ap_start, 0);
        chk("coinc_busy", bus.busy, 1);
        check_latency();
        drain(0);

        // Mask write during LOAD is dropped and flags err.
        bus.mask_img_ce0      = 1'b1;
        bus.mask_img_we0      = 1'b1;
        bus.mask_img_address0 = ADDR_W'(3);
        bus.mask_img_d0       = 32'h0000_DEAD;
        step();
        core_idle();
        chk("err_set", bus.err, 1);
        load_frame(NUM_PIX, 3);
        bus.ap_ready = 1'b1;
        bus.ap_done  = 1'b1;
        step();
        bus.ap_ready = 1'b0;
        bus.ap_done  = 1'b0;
        check_latency();
        drain(0);
        chk("mask3_kept", exp_mask[3], 32'h0000_1004);
        chk("err_sticky", bus.err, 1);

        // Reset after a partial frame, then a full frame of 7s.
        load_frame(500, 3);
        rst = 1'b0;
        #1;
        chk("midrst_in_ready", bus.in_ready, 0);
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_err", bus.err, 0);
        chk("midrst_img_q0", bus.img_q0, 0);
        chk("midrst_ap_start", bus.ap_start, 0);
        step();
        rst = 1'b1;
        #1;
        chk("midrst_rel_in_ready", bus.in_ready, 1);
        chk("midrst_rel_busy", bus.busy, 0);
        load_frame(NUM_PIX, 2);
        core_start(t0);
        core_rw();
        core_done(t0);
        check_latency();
        drain(0);
        chk("sevens_mask", exp_mask[NUM_PIX-1], 32'd8);
        chk("sevens_err", bus.err, 0);

        // Core reading img while still in LOAD is a protocol error.
        bus.img_ce0 = 1'b1;
        step();
        bus.img_ce0 = 1'b0;
        chk("err_img_in_load", bus.err, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
